hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_if.sv | 39 +++
 rtl/hazard_ctrl.sv | 79 +++++++
 tb/tb_hazard_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - hazard unit signal bundle between pipeline and hazard_ctrl
interface hazard_ctrl_if;
    logic [4:0] rs_D;
    logic [4:0] rt_D;
    logic [1:0] tuse_rs_D;
    logic [1:0] tuse_rt_D;
    logic       md_use_D;
    logic [4:0] a3_E;
    logic [4:0] a3_M;
    logic       regwrite_E;
    logic       regwrite_M;
    logic [1:0] tnew_E;
    logic [1:0] tnew_M;
    logic       link_M;
    logic       md_start_E;
    logic       md_div_E;
    logic       stall;
    logic [1:0] rs_Dforward;
    logic [1:0] rt_Dforward;
    logic       md_busy;
    logic [3:0] md_cnt;
    logic       md_err;

    // Pipeline side: drives stage information, receives stall/forward/mult-div status
    modport master (
        output rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_use_D,
        output a3_E, a3_M, regwrite_E, regwrite_M, tnew_E, tnew_M, link_M,
        output md_start_E, md_div_E,
        input  stall, rs_Dforward, rt_Dforward, md_busy, md_cnt, md_err
    );

    // Hazard unit side
    modport slave (
        input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_use_D,
        input  a3_E, a3_M, regwrite_E, regwrite_M, tnew_E, tnew_M, link_M,
        input  md_start_E, md_div_E,
        output stall, rs_Dforward, rt_Dforward, md_busy, md_cnt, md_err
    );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - Tuse/Tnew stall, D-stage forward select and mult/div busy tracking
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);
    localparam logic [3:0] LP_MULT = 4'(MULT_CYCLES);
    localparam logic [3:0] LP_DIV  = 4'(DIV_CYCLES);

    logic [3:0] r_md_cnt;
    logic       r_md_err;

    logic       w_rs_match_E;
    logic       w_rt_match_E;
    logic       w_rs_match_M;
    logic       w_rt_match_M;
    logic [1:0] w_tnew_E_eff;
    logic       w_rs_stall;
    logic       w_rt_stall;
    logic       w_md_busy;
    logic       w_md_accept;

    // A register 0 source never depends on anything; tuse 3 marks an unused operand
    assign w_rs_match_E = (hz.rs_D != 5'd0) && hz.regwrite_E && (hz.rs_D == hz.a3_E) && (hz.tuse_rs_D != 2'd3);
    assign w_rt_match_E = (hz.rt_D != 5'd0) && hz.regwrite_E && (hz.rt_D == hz.a3_E) && (hz.tuse_rt_D != 2'd3);
    assign w_rs_match_M = (hz.rs_D != 5'd0) && hz.regwrite_M && (hz.rs_D == hz.a3_M) && (hz.tuse_rs_D != 2'd3);
    assign w_rt_match_M = (hz.rt_D != 5'd0) && hz.regwrite_M && (hz.rt_D == hz.a3_M) && (hz.tuse_rt_D != 2'd3);

    // An E-stage result is never forwardable to D in the same cycle, so treat tnew 0 as 1
    assign w_tnew_E_eff = (hz.tnew_E == 2'd0) ? 2'd1 : hz.tnew_E;

    assign w_rs_stall = (w_rs_match_E && (w_tnew_E_eff > hz.tuse_rs_D)) ||
                        (w_rs_match_M && (hz.tnew_M > hz.tuse_rs_D));
    assign w_rt_stall = (w_rt_match_E && (w_tnew_E_eff > hz.tuse_rt_D)) ||
                        (w_rt_match_M && (hz.tnew_M > hz.tuse_rt_D));

    assign w_md_busy   = hz.md_start_E || (r_md_cnt != 4'd0);
    assign w_md_accept = hz.md_start_E && (r_md_cnt == 4'd0);

    assign hz.stall   = w_rs_stall || w_rt_stall || (hz.md_use_D && w_md_busy);
    assign hz.md_busy = w_md_busy;
    assign hz.md_cnt  = r_md_cnt;
    assign hz.md_err  = r_md_err;

    // Forward select: only a ready M-stage result is bypassed; PC+8 for link instructions
    always_comb begin
        hz.rs_Dforward = 2'd0;
        hz.rt_Dforward = 2'd0;
        if (w_rs_match_M && (hz.tnew_M == 2'd0)) begin
            hz.rs_Dforward = hz.link_M ? 2'd2 : 2'd1;
        end
        if (w_rt_match_M && (hz.tnew_M == 2'd0)) begin
            hz.rt_Dforward = hz.link_M ? 2'd2 : 2'd1;
        end
    end

    // Busy counter: load on an accepted issue, count down to zero, never wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_md_cnt <= 4'd0;
        end else if (w_md_accept) begin
            r_md_cnt <= hz.md_div_E ? LP_DIV : LP_MULT;
        end else if (r_md_cnt != 4'd0) begin
            r_md_cnt <= r_md_cnt - 4'd1;
        end
    end

    // Sticky error: an issue attempted while the unit is still counting is dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_md_err <= 1'b0;
        end else if (hz.md_start_E && (r_md_cnt != 4'd0)) begin
            r_md_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    hazard_ctrl_if hz ();

    hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        hz.rs_D = 5'd0;       hz.rt_D = 5'd0;
        hz.tuse_rs_D = 2'd3;  hz.tuse_rt_D = 2'd3;
        hz.md_use_D = 1'b0;
        hz.a3_E = 5'd0;       hz.a3_M = 5'd0;
        hz.regwrite_E = 1'b0; hz.regwrite_M = 1'b0;
        hz.tnew_E = 2'd0;     hz.tnew_M = 2'd0;
        hz.link_M = 1'b0;
        hz.md_start_E = 1'b0; hz.md_div_E = 1'b0;
    endtask

    // Advance to the next cycle; inputs are then driven 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        hz.tuse_rs_D = 2'd0;
        hz.tuse_rt_D = 2'd0;
        #12;
        checks++;
        if (hz.stall !== 1'b0 || hz.rs_Dforward !== 2'd0 || hz.rt_Dforward !== 2'd0 || hz.md_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: stall=%b rsf=%0d rtf=%0d busy=%b, expected 0 0 0 0",
                     hz.stall, hz.rs_Dforward, hz.rt_Dforward, hz.md_busy);
        end
        checks++;
        if (hz.md_cnt !== 4'd0 || hz.md_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: md_cnt=%0d md_err=%b, expected 0 0", hz.md_cnt, hz.md_err);
        end
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_load_use();
        clear_inputs();
        hz.a3_E = 5'd8; hz.regwrite_E = 1'b1; hz.tnew_E = 2'd2;
        hz.rs_D = 5'd8; hz.tuse_rs_D = 2'd1;
        #1;
        checks++;
        if (hz.stall !== 1'b1) begin
            errors++;
            $display("FAIL load_use_stall: stall=%b expected 1", hz.stall);
        end
        hz.tnew_E = 2'd1;
        #1;
        checks++;
        if (hz.stall !== 1'b0) begin
            errors++;
            $display("FAIL alu_no_stall: stall=%b expected 0", hz.stall);
        end
        hz.tnew_E = 2'd2; hz.tuse_rs_D = 2'd3;
        #1;
        checks++;
        if (hz.stall !== 1'b0) begin
            errors++;
            $display("FAIL unused_operand: stall=%b expected 0", hz.stall);
        end
        hz.rs_D = 5'd0; hz.a3_E = 5'd0; hz.tuse_rs_D = 2'd0;
        #1;
        checks++;
        if (hz.stall !== 1'b0) begin
            errors++;
            $display("FAIL reg_zero_no_stall: stall=%b expected 0", hz.stall);
        end
        hz.rs_D = 5'd0; hz.rt_D = 5'd8; hz.a3_E = 5'd8; hz.tuse_rt_D = 2'd1; hz.tnew_E = 2'd2;
        #1;
        checks++;
        if (hz.stall !== 1'b1) begin
            errors++;
            $display("FAIL rt_load_use: stall=%b expected 1", hz.stall);
        end
    endtask

    task automatic test_m_forward();
        clear_inputs();
        hz.a3_M = 5'd9; hz.regwrite_M = 1'b1; hz.tnew_M = 2'd0;
        hz.rt_D = 5'd9; hz.tuse_rt_D = 2'd0;
        #1;
        checks++;
        if (hz.rt_Dforward !== 2'd1 || hz.stall !== 1'b0) begin
            errors++;
            $display("FAIL m_forward_alu: rtf=%0d stall=%b expected 1 0", hz.rt_Dforward, hz.stall);
        end
        hz.link_M = 1'b1;
        #1;
        checks++;
        if (hz.rt_Dforward !== 2'd2) begin
            errors++;
            $display("FAIL m_forward_link: rtf=%0d expected 2", hz.rt_Dforward);
        end
        hz.rt_D = 5'd0;
        #1;
        checks++;
        if (hz.rt_Dforward !== 2'd0) begin
            errors++;
            $display("FAIL m_forward_zero: rtf=%0d expected 0", hz.rt_Dforward);
        end
        hz.link_M = 1'b0; hz.rs_D = 5'd9; hz.tuse_rs_D = 2'd0; hz.tnew_M = 2'd1;
        #1;
        checks++;
        if (hz.stall !== 1'b1 || hz.rs_Dforward !== 2'd0) begin
            errors++;
            $display("FAIL m_load_stall: stall=%b rsf=%0d expected 1 0", hz.stall, hz.rs_Dforward);
        end
    endtask

    task automatic test_branch_alu();
        clear_inputs();
        step();
        hz.a3_E = 5'd4; hz.regwrite_E = 1'b1; hz.tnew_E = 2'd1;
        hz.rs_D = 5'd4; hz.tuse_rs_D = 2'd0;
        @(negedge clk);
        checks++;
        if (hz.stall !== 1'b1) begin
            errors++;
            $display("FAIL branch_e_stall: stall=%b expected 1", hz.stall);
        end
        step();
        hz.a3_E = 5'd0; hz.regwrite_E = 1'b0; hz.tnew_E = 2'd0;
        hz.a3_M = 5'd4; hz.regwrite_M = 1'b1; hz.tnew_M = 2'd0;
        @(negedge clk);
        checks++;
        if (hz.stall !== 1'b0 || hz.rs_Dforward !== 2'd1) begin
            errors++;
            $display("FAIL branch_m_forward: stall=%b rsf=%0d expected 0 1", hz.stall, hz.rs_Dforward);
        end
        clear_inputs();
        hz.a3_E = 5'd4; hz.regwrite_E = 1'b1; hz.tnew_E = 2'd0;
        hz.rs_D = 5'd4; hz.tuse_rs_D = 2'd0;
        #1;
        checks++;
        if (hz.stall !== 1'b1) begin
            errors++;
            $display("FAIL e_tnew0_stall: stall=%b expected 1", hz.stall);
        end
    endtask

    task automatic test_mult();
        clear_inputs();
        step();
        hz.md_start_E = 1'b1; hz.md_div_E = 1'b0;
        @(negedge clk);
        checks++;
        if (hz.md_busy !== 1'b1 || hz.md_cnt !== 4'd0) begin
            errors++;
            $display("FAIL mult_issue: busy=%b cnt=%0d expected 1 0", hz.md_busy, hz.md_cnt);
        end
        step();
        hz.md_start_E = 1'b0; hz.md_use_D = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            checks++;
            if (hz.md_cnt !== 4'(6 - i) || hz.stall !== 1'b1) begin
                errors++;
                $display("FAIL mult_cycle%0d: cnt=%0d stall=%b expected %0d 1", i, hz.md_cnt, hz.stall, 6 - i);
            end
            step();
        end
        @(negedge clk);
        checks++;
        if (hz.md_cnt !== 4'd0 || hz.stall !== 1'b0 || hz.md_busy !== 1'b0) begin
            errors++;
            $display("FAIL mult_done: cnt=%0d stall=%b busy=%b expected 0 0 0", hz.md_cnt, hz.stall, hz.md_busy);
        end
        step();
        @(negedge clk);
        checks++;
        if (hz.md_cnt !== 4'd0) begin
            errors++;
            $display("FAIL mult_no_wrap: cnt=%0d expected 0", hz.md_cnt);
        end
        hz.md_use_D = 1'b0;
    endtask

    task automatic test_div_collision();
        clear_inputs();
        step();
        hz.md_start_E = 1'b1; hz.md_div_E = 1'b1;
        step();
        hz.md_start_E = 1'b0; hz.md_div_E = 1'b0;
        @(negedge clk);
        checks++;
        if (hz.md_cnt !== 4'd10) begin
            errors++;
            $display("FAIL div_load: cnt=%0d expected 10", hz.md_cnt);
        end
        step();
        step();
        hz.md_start_E = 1'b1;
        @(negedge clk);
        checks++;
        if (hz.md_cnt !== 4'd8 || hz.md_err !== 1'b0) begin
            errors++;
            $display("FAIL div_cycle3: cnt=%0d err=%b expected 8 0", hz.md_cnt, hz.md_err);
        end
        step();
        hz.md_start_E = 1'b0;
        @(negedge clk);
        checks++;
        if (hz.md_cnt !== 4'd7 || hz.md_err !== 1'b1) begin
            errors++;
            $display("FAIL div_collision: cnt=%0d err=%b expected 7 1", hz.md_cnt, hz.md_err);
        end
        for (int i = 0; i < 7; i++) step();
        @(negedge clk);
        checks++;
        if (hz.md_cnt !== 4'd0 || hz.md_err !== 1'b1) begin
            errors++;
            $display("FAIL div_drain_sticky: cnt=%0d err=%b expected 0 1", hz.md_cnt, hz.md_err);
        end
    endtask

    task automatic test_async_reset();
        clear_inputs();
        step();
        hz.md_start_E = 1'b1; hz.md_div_E = 1'b1;
        step();
        hz.md_start_E = 1'b0; hz.md_div_E = 1'b0;
        step();
        step();
        @(negedge clk);
        checks++;
        if (hz.md_cnt !== 4'd8 || hz.md_err !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: cnt=%0d err=%b expected 8 1", hz.md_cnt, hz.md_err);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (hz.md_cnt !== 4'd0 || hz.md_busy !== 1'b0 || hz.md_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: cnt=%0d busy=%b err=%b expected 0 0 0", hz.md_cnt, hz.md_busy, hz.md_err);
        end
        hz.md_start_E = 1'b1;
        #1;
        checks++;
        if (hz.md_busy !== 1'b1 || hz.md_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_busy_follows_start: busy=%b cnt=%0d expected 1 0", hz.md_busy, hz.md_cnt);
        end
        hz.md_start_E = 1'b0;
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_m_forward();
        test_branch_alu();
        test_mult();
        test_div_collision();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
